// File: rtl/riscv_pkg.sv
// -----------------------------------------------------------------------------
// riscv_pkg
// Shared constants and types for the fetch front end.
//   XLEN          : architectural register / address width
//   NOP_INSTR     : canonical NOP (addi x0,x0,0) used for pipeline bubbles
//   RESET_PC_DEF  : default first fetch address after reset
//   if_id_t       : contents of the IF/ID pipeline register
//   word_align()  : clears the two low address bits (fetch is 32-bit only)
// -----------------------------------------------------------------------------
package riscv_pkg;

   localparam int XLEN = 32;

   localparam logic [XLEN-1:0] NOP_INSTR    = 32'h0000_0013;
   localparam logic [XLEN-1:0] RESET_PC_DEF = 32'h0000_0000;

   typedef struct packed {
      logic            valid;
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] instr;
   } if_id_t;

   // Masking (rather than slicing) keeps every input bit in use.
   function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] a);
      return a & 32'hFFFF_FFFC;
   endfunction

endpackage

// File: rtl/fetch_buffer.sv
// -----------------------------------------------------------------------------
// fetch_buffer
// Circular buffer tracking fetches from request to decode.
//   alloc pointer : advances on request handshake, records the request PC
//   fill pointer  : advances on each accepted response, records the instruction
//   head pointer  : advances when the head entry is popped into IF/ID
// An entry is "filled" when the fill pointer has moved past it. On flush every
// entry is freed and responses still owed by memory are counted in drop_cnt so
// they are discarded when they arrive.
// Ports:
//   clk, rst_n            clock / async active-low reset
//   i_alloc, i_alloc_pc   allocate an entry for an accepted request
//   i_fill, i_fill_instr  memory response
//   i_pop                 consume head entry
//   i_flush               free all entries (redirect)
//   o_head_filled         head entry holds a returned instruction
//   o_head_pc/o_head_instr contents of head entry
//   o_count               allocated entries (alloc - head)
//   o_spurious            response arrived with nothing to fill or drop
// -----------------------------------------------------------------------------
module fetch_buffer
   import riscv_pkg::*;
#(
   parameter int DEPTH  = 4,
   parameter int DROP_W = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     i_alloc,
   input  logic [XLEN-1:0]          i_alloc_pc,
   input  logic                     i_fill,
   input  logic [XLEN-1:0]          i_fill_instr,
   input  logic                     i_pop,
   input  logic                     i_flush,
   output logic                     o_head_filled,
   output logic [XLEN-1:0]          o_head_pc,
   output logic [XLEN-1:0]          o_head_instr,
   output logic [$clog2(DEPTH):0]   o_count,
   output logic                     o_spurious
);

   localparam int PW = $clog2(DEPTH);

   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   logic [PW:0]       r_alloc_ptr;
   logic [PW:0]       r_fill_ptr;
   logic [PW:0]       r_head_ptr;
   logic [DROP_W-1:0] r_drop_cnt;
   logic [XLEN-1:0]   r_pc_mem    [DEPTH];
   logic [XLEN-1:0]   r_instr_mem [DEPTH];

   logic [PW:0]       w_unfilled;
   logic              w_drop_now;
   logic              w_fill_now;
   logic [DROP_W-1:0] w_drop_next;

   assign w_unfilled    = r_alloc_ptr - r_fill_ptr;
   // Pending drops are older than any live entry, so they are consumed first.
   assign w_drop_now    = i_fill && (r_drop_cnt != '0);
   assign w_fill_now    = i_fill && !w_drop_now && (w_unfilled != '0);
   assign o_spurious    = i_fill && !w_drop_now && (w_unfilled == '0);
   // Reads registered pointers only: a fill in this cycle is visible next cycle.
   assign o_head_filled = (r_fill_ptr != r_head_ptr);
   assign o_head_pc     = r_pc_mem[r_head_ptr[PW-1:0]];
   assign o_head_instr  = r_instr_mem[r_head_ptr[PW-1:0]];
   assign o_count       = r_alloc_ptr - r_head_ptr;

   // Next drop count: on flush every response still owed (old drops, unfilled
   // entries, a request accepted this cycle) minus the one arriving now.
   always_comb begin
      w_drop_next = r_drop_cnt;
      if (i_flush) begin
         w_drop_next = r_drop_cnt
                     - DROP_W'(w_drop_now)
                     + DROP_W'(w_unfilled)
                     - DROP_W'(w_fill_now)
                     + DROP_W'(i_alloc);
      end else begin
         w_drop_next = r_drop_cnt - DROP_W'(w_drop_now);
      end
   end

   // Pointer and drop-counter registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_alloc_ptr <= '0;
         r_fill_ptr  <= '0;
         r_head_ptr  <= '0;
         r_drop_cnt  <= '0;
      end else if (i_flush) begin
         r_alloc_ptr <= '0;
         r_fill_ptr  <= '0;
         r_head_ptr  <= '0;
         r_drop_cnt  <= w_drop_next;
      end else begin
         r_alloc_ptr <= r_alloc_ptr + {{PW{1'b0}}, i_alloc};
         r_fill_ptr  <= r_fill_ptr  + {{PW{1'b0}}, w_fill_now};
         r_head_ptr  <= r_head_ptr  + {{PW{1'b0}}, i_pop};
         r_drop_cnt  <= w_drop_next;
      end
   end

   // Entry storage; validity is tracked by the pointers, so no reset needed.
   always_ff @(posedge clk) begin
      if (i_alloc) begin
         r_pc_mem[r_alloc_ptr[PW-1:0]] <= i_alloc_pc;
      end
      if (w_fill_now) begin
         r_instr_mem[r_fill_ptr[PW-1:0]] <= i_fill_instr;
      end
   end

endmodule

// File: rtl/if_stage_chk.sv
// -----------------------------------------------------------------------------
// if_stage_chk
// Run-time checks for the fetch stage.
//   clk, rst_n    clock / async active-low reset
//   i_spurious    memory response with no entry to fill and nothing to drop
// -----------------------------------------------------------------------------
module if_stage_chk (
   input logic clk,
   input logic rst_n,
   input logic i_spurious
);

   a_no_spurious_rsp: assert property (@(posedge clk) disable iff (!rst_n) !i_spurious);

endmodule

// File: rtl/if_stage.sv
// -----------------------------------------------------------------------------
// if_stage
// Instruction-fetch stage: owns the PC, issues in-order requests to instruction
// memory, buffers responses in fetch_buffer and drives the IF/ID register.
// Ports:
//   clk, rst_n                         clock / async active-low reset
//   imem_req_valid/ready/addr          fetch request channel (addr = pc)
//   imem_rsp_valid/data                in-order responses, latency >= 1
//   redirect, redirect_pc              taken branch/jump from EX (flush)
//   stall                              hold IF/ID (load-use hazard)
//   id_valid, id_pc, id_instr          IF/ID register to decode
// -----------------------------------------------------------------------------
module if_stage
   import riscv_pkg::*;
#(
   parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
   parameter int          BUF_DEPTH = 4
) (
   input  logic            clk,
   input  logic            rst_n,
   output logic            imem_req_valid,
   input  logic            imem_req_ready,
   output logic [XLEN-1:0] imem_req_addr,
   input  logic            imem_rsp_valid,
   input  logic [XLEN-1:0] imem_rsp_data,
   input  logic            redirect,
   input  logic [XLEN-1:0] redirect_pc,
   input  logic            stall,
   output logic            id_valid,
   output logic [XLEN-1:0] id_pc,
   output logic [XLEN-1:0] id_instr
);

   localparam int          PW      = $clog2(BUF_DEPTH);
   localparam logic [PW:0] DEPTH_L = (PW+1)'(BUF_DEPTH);

   logic [XLEN-1:0] r_pc;
   logic            r_run;
   if_id_t          r_if_id;
   if_id_t          w_if_id_next;

   logic            w_head_filled;
   logic [XLEN-1:0] w_head_pc;
   logic [XLEN-1:0] w_head_instr;
   logic [PW:0]     w_count;
   logic [PW:0]     w_count_after_pop;
   logic            w_pop;
   logic            w_hs;
   logic            w_spurious;

   assign w_pop             = !redirect && !stall && w_head_filled;
   // The slot freed by this cycle's pop may be reused by this cycle's request,
   // which is what sustains one fetch per cycle.
   assign w_count_after_pop = w_count - {{PW{1'b0}}, w_pop};
   // r_run keeps the request low while reset is held and for the first cycle.
   assign imem_req_valid    = r_run && !redirect && (w_count_after_pop < DEPTH_L);
   assign imem_req_addr     = r_pc;
   assign w_hs              = imem_req_valid && imem_req_ready;

   assign id_valid = r_if_id.valid;
   assign id_pc    = r_if_id.pc;
   assign id_instr = r_if_id.instr;

   fetch_buffer #(
      .DEPTH  (BUF_DEPTH),
      .DROP_W (8)
   ) u_fetch_buffer (
      .clk           (clk),
      .rst_n         (rst_n),
      .i_alloc       (w_hs),
      .i_alloc_pc    (r_pc),
      .i_fill        (imem_rsp_valid),
      .i_fill_instr  (imem_rsp_data),
      .i_pop         (w_pop),
      .i_flush       (redirect),
      .o_head_filled (w_head_filled),
      .o_head_pc     (w_head_pc),
      .o_head_instr  (w_head_instr),
      .o_count       (w_count),
      .o_spurious    (w_spurious)
   );

   if_stage_chk u_chk (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_spurious (w_spurious)
   );

   // Run flag: requests start the cycle after reset is released.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_run <= 1'b0;
      end else begin
         r_run <= 1'b1;
      end
   end

   // PC register: redirect wins, otherwise advance on handshake.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pc <= RESET_PC;
      end else if (redirect) begin
         r_pc <= word_align(redirect_pc);
      end else if (w_hs) begin
         r_pc <= r_pc + 32'd4;
      end else begin
         r_pc <= r_pc;
      end
   end

   // IF/ID next state: redirect > stall > load head > bubble.
   always_comb begin
      w_if_id_next = r_if_id;
      if (redirect) begin
         w_if_id_next.valid = 1'b0;
         w_if_id_next.instr = NOP_INSTR;
      end else if (stall) begin
         w_if_id_next = r_if_id;
      end else if (w_head_filled) begin
         w_if_id_next.valid = 1'b1;
         w_if_id_next.pc    = w_head_pc;
         w_if_id_next.instr = w_head_instr;
      end else begin
         w_if_id_next.valid = 1'b0;
         w_if_id_next.instr = NOP_INSTR;
      end
   end

   // IF/ID register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_if_id <= '{valid: 1'b0, pc: 32'h0000_0000, instr: NOP_INSTR};
      end else begin
         r_if_id <= w_if_id_next;
      end
   end

endmodule
